// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 4-digit 7-segment scan controller with guard interval and frame-aligned double buffering
module sseg_scan_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 1000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_mask_i,
    input  logic [3:0]  blank_mask_i,
    input  logic        lzb_i,
    output logic [3:0]  an_o,
    output logic [6:0]  segs_o,
    output logic        dp_n_o,
    output logic        pend_o,
    output logic        frame_done_o
);

    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic {DARK, LIT} phase_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          frame_done_q;
    phase_e        state_q;

    logic [15:0] act_data_q, pnd_data_q;
    logic [3:0]  act_dp_q, act_blank_q, pnd_dp_q, pnd_blank_q;
    logic        pend_q;

    logic [3:0]  an_q;
    logic [6:0]  segs_q;
    logic        dp_n_q;

    logic        tick, boundary, guard_end;
    logic [3:0]  nib;
    logic        lzb_dark, digit_dark;

    assign tick      = (cnt_q == CW'(CLK_DIV - 1));
    assign boundary  = tick && (idx_q == 2'd3);
    assign guard_end = (cnt_q == CW'(GUARD - 1));
    assign cnt_d     = tick ? '0 : cnt_q + CW'(1);
    assign idx_d     = tick ? idx_q + 2'd1 : idx_q;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // A digit is leading-zero dark only if it and every digit to its left are zero.
    always_comb begin
        nib      = act_data_q[3:0];
        lzb_dark = 1'b0;
        case (idx_q)
            2'd0: nib = act_data_q[3:0];
            2'd1: begin
                nib      = act_data_q[7:4];
                lzb_dark = (act_data_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib      = act_data_q[11:8];
                lzb_dark = (act_data_q[15:8] == 8'h00);
            end
            default: begin
                nib      = act_data_q[15:12];
                lzb_dark = (act_data_q[15:12] == 4'h0);
            end
        endcase
        digit_dark = act_blank_q[idx_q] | (lzb_i & lzb_dark);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= boundary;
        end
    end

    // A load landing on the boundary cycle bypasses the pending stage entirely.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            pnd_data_q  <= '0;
            pnd_dp_q    <= '0;
            pnd_blank_q <= '0;
            pend_q      <= 1'b0;
        end else if (boundary && load_i) begin
            act_data_q  <= data_i;
            act_dp_q    <= dp_mask_i;
            act_blank_q <= blank_mask_i;
            pend_q      <= 1'b0;
        end else if (boundary && pend_q) begin
            act_data_q  <= pnd_data_q;
            act_dp_q    <= pnd_dp_q;
            act_blank_q <= pnd_blank_q;
            pend_q      <= 1'b0;
        end else if (load_i) begin
            pnd_data_q  <= data_i;
            pnd_dp_q    <= dp_mask_i;
            pnd_blank_q <= blank_mask_i;
            pend_q      <= 1'b1;
        end
    end

    // state_q always mirrors whether cnt_q is inside the guard window.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DARK;
            an_q    <= 4'b1111;
            segs_q  <= 7'h7F;
            dp_n_q  <= 1'b1;
        end else begin
            case (state_q)
                DARK:    if (guard_end) state_q <= LIT;
                default: if (tick)      state_q <= DARK;
            endcase
            if (state_q == LIT && en_i) begin
                an_q   <= ~(4'b0001 << idx_q);
                segs_q <= digit_dark ? 7'h7F : hex7(nib);
                dp_n_q <= digit_dark | ~act_dp_q[idx_q];
            end else begin
                an_q   <= 4'b1111;
                segs_q <= 7'h7F;
                dp_n_q <= 1'b1;
            end
        end
    end

    assign an_o         = an_q;
    assign segs_o       = segs_q;
    assign dp_n_o       = dp_n_q;
    assign pend_o       = pend_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed self-checking bench for sseg_scan_ctrl (CLK_DIV=8, GUARD=2)
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, load, lzb;
    logic [15:0] data;
    logic [3:0]  dp_mask, blank_mask;
    logic [3:0]  an;
    logic [6:0]  segs;
    logic        dp_n, pend, frame_done;

    int checks = 0;
    int errors = 0;
    int n;

    logic [15:0] m_act, m_pdata;
    logic [3:0]  m_adp, m_ablank, m_pdp, m_pblank;
    logic        m_pend;

    sseg_scan_ctrl #(.CLK_DIV(8), .GUARD(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .load_i(load),
        .data_i(data), .dp_mask_i(dp_mask), .blank_mask_i(blank_mask), .lzb_i(lzb),
        .an_o(an), .segs_o(segs), .dp_n_o(dp_n), .pend_o(pend), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s at n=%0d: observed %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    task automatic model_reset();
        n = 0; m_pend = 0;
        m_act = '0; m_adp = '0; m_ablank = '0;
        m_pdata = '0; m_pdp = '0; m_pblank = '0;
    endtask

    task automatic step();
        logic       bnd, lit, blk, z;
        int         k;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        bnd = (n % 32 == 31);
        k   = (n / 8) % 4;
        lit = en && (n % 8 >= 2);
        z   = 1'b1;
        for (int j = 3; j >= 1; j--)
            if (j >= k) z = z && (m_act[j*4 +: 4] == 4'h0);
        blk = m_ablank[k] || (lzb && k != 0 && z);
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        if (lit) begin
            e_an = ~(4'b0001 << k);
            if (!blk) begin
                e_seg = hex7(m_act[k*4 +: 4]);
                e_dp  = ~m_adp[k];
            end
        end
        if (load && bnd) begin
            m_act = data; m_adp = dp_mask; m_ablank = blank_mask; m_pend = 0;
        end else if (bnd && m_pend) begin
            m_act = m_pdata; m_adp = m_pdp; m_ablank = m_pblank; m_pend = 0;
        end else if (load) begin
            m_pdata = data; m_pdp = dp_mask; m_pblank = blank_mask; m_pend = 1;
        end
        @(posedge clk);
        #1;
        n++;
        chk("an", 16'(an), 16'(e_an));
        chk("segs", 16'(segs), 16'(e_seg));
        chk("dp_n", 16'(dp_n), 16'(e_dp));
        chk("frame_done", 16'(frame_done), 16'(bnd));
        chk("pend", 16'(pend), 16'(m_pend));
        chk("one_cold", 16'($countones(~an) <= 1), 16'd1);
    endtask

    task automatic run(input int c);
        for (int i = 0; i < c; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b0; lzb = 1'b0;
        data = '0; dp_mask = '0; blank_mask = '0;
        model_reset();
        #8;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_segs", 16'(segs), 16'h7F);
        chk("rst_dp", 16'(dp_n), 16'd1);
        chk("rst_pend", 16'(pend), 16'd0);
        chk("rst_fd", 16'(frame_done), 16'd0);
        #4 rst_n = 1'b1;

        // free-running scan of zeros, first lit window after two dark clocks
        run(2);
        chk("first_dark", 16'(an), 16'hF);
        step();
        chk("first_lit_an", 16'(an), 16'hE);
        chk("first_lit_seg", 16'(segs), 16'h40);
        run(29);

        // load mid-digit-1, held until the frame boundary
        run(11);
        data = 16'h12AF; load = 1'b1;
        step();
        load = 1'b0;
        chk("pend_set", 16'(pend), 16'd1);
        run(20);
        chk("pend_clear", 16'(pend), 16'd0);
        run(3);
        chk("dig0_F", 16'(segs), 16'h0E);
        run(8);
        chk("dig1_A", 16'(segs), 16'h08);
        run(8);
        chk("dig2_2", 16'(segs), 16'h24);
        run(8);
        chk("dig3_1", 16'(segs), 16'h79);
        run(5);

        // load on the boundary cycle goes straight to the display
        run(31);
        data = 16'h0000; dp_mask = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        chk("bypass_no_pend", 16'(pend), 16'd0);
        run(32);

        // leading-zero blanking, then all lit
        data = 16'h0050; dp_mask = 4'b0000; blank_mask = 4'b0000; load = 1'b1;
        step();
        load = 1'b0; lzb = 1'b1;
        run(31);
        run(32);
        lzb = 1'b0;
        run(32);

        // blank mask pending across an enable toggle mid-slot
        data = 16'h1234; blank_mask = 4'b0010; load = 1'b1;
        step();
        load = 1'b0;
        run(2);
        en = 1'b0;
        step();
        chk("en_off_dark", 16'(an), 16'hF);
        run(3);
        en = 1'b1;
        run(40);

        // reset mid-frame with pending data
        data = 16'hFFFF; blank_mask = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        run(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_an", 16'(an), 16'hF);
        chk("midrst_segs", 16'(segs), 16'h7F);
        chk("midrst_pend", 16'(pend), 16'd0);
        #2 rst_n = 1'b1;
        model_reset();
        run(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
